fetch_unit: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RISC-V pipeline. Owns the program counter, issues one-outstanding requests to instruction memory with variable response latency, and presents the fetched instruction, its PC and PC+4 to the decode stage. Handles hazard-unit stalls on decode, flushes of the IF/ID register, and branch/jump redirects from execute, discarding any stale in-flight response.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if_id_reg.sv | 46 ++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID register.
// The IF/ID struct is also consumed by the decode stage.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold,
        StDrop
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
// Flushes and bubbles leave the PC fields untouched.
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   stall_i,
    input  logic   flush_i,
    input  logic   load_i,
    input  if_id_t data_i,
    output if_id_t q_o
);

    if_id_t q_q;
    if_id_t q_d;

    always_comb begin
        q_d = q_q;
        if (flush_i) begin
            q_d.valid = 1'b0;
            q_d.instr = NOP_INSTR;
        end else if (stall_i) begin
            q_d = q_q;
        end else if (load_i) begin
            q_d = data_i;
        end else begin
            q_d.valid = 1'b0;
            q_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q.instr    <= NOP_INSTR;
            q_q.pc       <= 32'h0;
            q_q.pc_plus4 <= 32'h0;
            q_q.valid    <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PCF, keeps one imem request outstanding, buffers a response
// that lands during a decode stall, and drops responses made stale by a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  pc_plus4;
    logic         load;
    logic [31:0]  load_instr;
    if_id_t       if_id_in;
    if_id_t       if_id_q;

    assign pc_plus4 = pc_inc(pc_q);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        load       = 1'b0;
        load_instr = ImemRdata;
        ImemReq    = 1'b0;
        ImemAddr   = pc_q;
        unique case (state_q)
            StReq: begin
                // The request goes out even on a redirect; DROP then swallows its response.
                ImemReq = 1'b1;
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = StDrop;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = ImemValid ? StReq : StDrop;
                end else if (ImemValid) begin
                    if (!StallD) begin
                        load     = 1'b1;
                        pc_d     = pc_plus4;
                        ImemReq  = 1'b1;
                        ImemAddr = pc_plus4;
                    end else begin
                        buf_d   = ImemRdata;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = StReq;
                end else if (!StallD) begin
                    load       = 1'b1;
                    load_instr = buf_q;
                    pc_d       = pc_plus4;
                    state_d    = StReq;
                end
            end
            StDrop: begin
                if (PCSrcE) begin
                    pc_d = PCTargetE;
                end
                if (ImemValid) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    assign if_id_in.instr    = load_instr;
    assign if_id_in.pc       = pc_q;
    assign if_id_in.pc_plus4 = pc_plus4;
    assign if_id_in.valid    = 1'b1;

    fetch_unit_if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .stall_i (StallD),
        .flush_i (FlushD),
        .load_i  (load),
        .data_i  (if_id_in),
        .q_o     (if_id_q)
    );

    assign InstrD   = if_id_q.instr;
    assign PCD      = if_id_q.pc;
    assign PCPlus4D = if_id_q.pc_plus4;
    assign ValidD   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push cycle-stamped expected
// requests and decode-stage outputs; a negedge monitor pops and compares them.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        req2, valid2, vd2;
    logic [31:0] addr2, rdata2, instr2, pcd2, pcp42, addr2_q;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int mem_lat = 1;

    exp_t req_q[$];
    exp_t out_q[$];
    exp_t req2_q[$];
    exp_t e, o, r;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemValid (ImemValid),
        .ImemRdata (ImemRdata),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .StallD    (1'b0),
        .FlushD    (1'b0),
        .PCSrcE    (1'b0),
        .PCTargetE (32'h0),
        .ImemReq   (req2),
        .ImemAddr  (addr2),
        .ImemValid (valid2),
        .ImemRdata (rdata2),
        .InstrD    (instr2),
        .PCD       (pcd2),
        .PCPlus4D  (pcp42),
        .ValidD    (vd2)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Variable-latency instruction memory, reset together with the DUT.
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_addr    <= 32'h0;
            ImemValid <= 1'b0;
            ImemRdata <= 32'h0;
        end else begin
            ImemValid <= 1'b0;
            if (ImemReq) begin
                if (mem_lat == 1) begin
                    ImemValid <= 1'b1;
                    ImemRdata <= data_of(ImemAddr);
                end else begin
                    m_busy <= 1'b1;
                    m_cnt  <= mem_lat - 1;
                    m_addr <= ImemAddr;
                end
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    ImemValid <= 1'b1;
                    ImemRdata <= data_of(m_addr);
                    m_busy    <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            valid2  <= 1'b0;
            addr2_q <= 32'h0;
        end else begin
            valid2  <= req2;
            addr2_q <= addr2;
        end
    end
    assign rdata2 = data_of(addr2_q);

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: decode consumes IF/ID whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (ImemReq && req_q.size() != 0) begin
                e = req_q.pop_front();
                n_checks++;
                if (cyc != e.cyc || ImemAddr !== e.val) begin
                    n_errors++;
                    $display("FAIL imem_req: got addr %h at cycle %0d, expected %h at cycle %0d",
                             ImemAddr, cyc, e.val, e.cyc);
                end
            end
            if (ValidD && !StallD && out_q.size() != 0) begin
                o = out_q.pop_front();
                n_checks++;
                if (cyc != o.cyc || InstrD !== data_of(o.val) || PCD !== o.val ||
                    PCPlus4D !== o.val + 32'd4) begin
                    n_errors++;
                    $display("FAIL if_id: got instr %h pc %h pc4 %h at cycle %0d, expected %h %h %h at cycle %0d",
                             InstrD, PCD, PCPlus4D, cyc, data_of(o.val), o.val,
                             o.val + 32'd4, o.cyc);
                end
            end
            if (!ValidD) begin
                n_checks++;
                if (InstrD !== NOP) begin
                    n_errors++;
                    $display("FAIL bubble_nop: got instr %h at cycle %0d, expected %h",
                             InstrD, cyc, NOP);
                end
            end
            if (req2 && req2_q.size() != 0) begin
                r = req2_q.pop_front();
                n_checks++;
                if (cyc != r.cyc || addr2 !== r.val) begin
                    n_errors++;
                    $display("FAIL wrap_req: got addr %h at cycle %0d, expected %h at cycle %0d",
                             addr2, cyc, r.val, r.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push_req(input int c, input logic [31:0] a);
        exp_t t;
        t.cyc = c;
        t.val = a;
        req_q.push_back(t);
    endfunction

    function automatic void push_out(input int c, input logic [31:0] pc);
        exp_t t;
        t.cyc = c;
        t.val = pc;
        out_q.push_back(t);
    endfunction

    function automatic void push_req2(input int c, input logic [31:0] a);
        exp_t t;
        t.cyc = c;
        t.val = a;
        req2_q.push_back(t);
    endfunction

    task automatic begin_test(input int lat);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        mem_lat   = lat;
        req_q.delete();
        out_q.delete();
        req2_q.delete();
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_cyc: at cycle %0d, expected cycle %0d", cyc, n);
        end
    endtask

    task automatic end_test(input string name);
        chk({name, "_req_drained"}, 32'(req_q.size()), 32'd0);
        chk({name, "_out_drained"}, 32'(out_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and L=1 streaming; wrap instance checks PC rollover.
        begin_test(1);
        #1;
        chk("rst_validd", {31'h0, ValidD}, 32'd0);
        chk("rst_instrd", InstrD, NOP);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pcplus4d", PCPlus4D, 32'h0);
        for (int k = 0; k < 8; k++) push_req(k, 32'(4 * k));
        for (int k = 2; k < 8; k++) push_out(k, 32'(4 * (k - 2)));
        push_req2(0, 32'hFFFF_FFFC);
        push_req2(1, 32'h0000_0000);
        push_req2(2, 32'h0000_0004);
        release_rst();
        chk("first_req", {31'h0, ImemReq}, 32'd1);
        wait_cyc(2);
        chk("wrap_pcd", pcd2, 32'hFFFF_FFFC);
        chk("wrap_pcplus4d", pcp42, 32'h0);
        wait_cyc(9);
        end_test("l1");
        chk("wrap_req_drained", 32'(req2_q.size()), 32'd0);

        // L=3: request every 3 cycles, single-cycle ValidD pulses.
        begin_test(3);
        for (int k = 0; k < 5; k++) push_req(3 * k, 32'(4 * k));
        for (int k = 1; k < 5; k++) push_out(3 * k + 1, 32'(4 * (k - 1)));
        release_rst();
        wait_cyc(15);
        end_test("l3");

        // Stall while the response for PC 8 arrives.
        begin_test(1);
        push_req(0, 32'h0);
        push_req(1, 32'h4);
        push_req(2, 32'h8);
        push_req(7, 32'hC);
        push_req(8, 32'h10);
        push_req(9, 32'h14);
        push_out(2, 32'h0);
        push_out(6, 32'h4);
        push_out(7, 32'h8);
        push_out(9, 32'hC);
        push_out(10, 32'h10);
        release_rst();
        wait_cyc(3);
        StallD = 1'b1;
        wait_cyc(5);
        chk("hold_no_req", {31'h0, ImemReq}, 32'd0);
        chk("hold_pcd", PCD, 32'h4);
        wait_cyc(6);
        StallD = 1'b0;
        wait_cyc(11);
        end_test("stall");

        // Redirect while waiting, L=2: stale response dropped.
        begin_test(2);
        push_req(0, 32'h0);
        push_req(2, 32'h4);
        push_req(5, 32'h100);
        push_req(7, 32'h104);
        push_req(9, 32'h108);
        push_out(3, 32'h0);
        push_out(8, 32'h100);
        push_out(10, 32'h104);
        release_rst();
        wait_cyc(3);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        FlushD    = 1'b1;
        wait_cyc(4);
        PCSrcE = 1'b0;
        FlushD = 1'b0;
        chk("flush_validd", {31'h0, ValidD}, 32'd0);
        chk("flush_keeps_pcd", PCD, 32'h0);
        chk("flush_keeps_pcplus4d", PCPlus4D, 32'h4);
        chk("drop_no_req", {31'h0, ImemReq}, 32'd0);
        wait_cyc(11);
        end_test("redir_wait");

        // Redirect coincident with the response.
        begin_test(1);
        push_req(0, 32'h0);
        push_req(1, 32'h4);
        push_req(3, 32'h200);
        push_req(4, 32'h204);
        push_req(5, 32'h208);
        push_out(2, 32'h0);
        push_out(5, 32'h200);
        push_out(6, 32'h204);
        release_rst();
        wait_cyc(2);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h200;
        FlushD    = 1'b1;
        #1;
        chk("redir_valid_no_req", {31'h0, ImemReq}, 32'd0);
        wait_cyc(3);
        PCSrcE = 1'b0;
        FlushD = 1'b0;
        wait_cyc(7);
        end_test("redir_valid");

        // Redirect during HOLD discards the buffered word.
        begin_test(1);
        push_req(0, 32'h0);
        push_req(1, 32'h4);
        push_req(2, 32'h8);
        push_req(5, 32'h300);
        push_req(6, 32'h304);
        push_req(7, 32'h308);
        push_out(2, 32'h0);
        push_out(7, 32'h300);
        push_out(8, 32'h304);
        release_rst();
        wait_cyc(3);
        StallD = 1'b1;
        wait_cyc(4);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h300;
        FlushD    = 1'b1;
        wait_cyc(5);
        StallD = 1'b0;
        PCSrcE = 1'b0;
        FlushD = 1'b0;
        wait_cyc(9);
        end_test("redir_hold");

        // Asynchronous reset mid-WAIT takes effect between edges.
        begin_test(1);
        release_rst();
        wait_cyc(3);
        chk("pre_rst_validd", {31'h0, ValidD}, 32'd1);
        chk("pre_rst_pcd", PCD, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_validd", {31'h0, ValidD}, 32'd0);
        chk("async_rst_instrd", InstrD, NOP);
        chk("async_rst_pcd", PCD, 32'h0);
        chk("async_rst_pcplus4d", PCPlus4D, 32'h0);
        chk("async_rst_req", {31'h0, ImemReq}, 32'd1);
        chk("async_rst_addr", ImemAddr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
